// File: rtl/alu_rr_scheduler_pkg.sv
// Shared definitions for the round-robin ALU scheduler: ALU op codes and FSM states.
package alu_rr_scheduler_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_NOT = 3'b101;
   localparam logic [2:0] ALU_INC = 3'b110;
   localparam logic [2:0] ALU_DEC = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_RESP = 2'b10
   } state_t;

endpackage

// File: rtl/alu_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational pick starting at the pointer, pointer moves
// one past the winner whenever a grant is taken.
module alu_rr_scheduler_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            advance,
   output logic [NREQ-1:0] gnt_onehot,
   output logic [IDW-1:0]  gnt_idx
);

   logic [IDW-1:0] r_ptr;
   logic           w_any;

   assign w_any = |req;

   // Lowest requester overall, overridden by the lowest requester at or above the pointer.
   always_comb begin
      gnt_idx    = '0;
      gnt_onehot = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i]) gnt_idx = IDW'(i);
      end
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i] && (i >= int'(r_ptr))) gnt_idx = IDW'(i);
      end
      for (int i = 0; i < NREQ; i++) begin
         if (w_any && (gnt_idx == IDW'(i))) gnt_onehot[i] = 1'b1;
      end
   end

   // Pointer moves just past the winner, wrapping the last requester back to 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (advance && w_any) begin
         if (gnt_idx == IDW'(NREQ - 1)) r_ptr <= '0;
         else                           r_ptr <= gnt_idx + IDW'(1);
      end
   end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one external 4-bit ALU among NREQ requesters: round-robin accept,
// registered operands, one settle cycle, registered response held until consumed.
module alu_rr_scheduler #(
   parameter int NREQ = 4,
   parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [4*NREQ-1:0] req_a,
   input  logic [4*NREQ-1:0] req_b,
   input  logic [3*NREQ-1:0] req_sel,
   output logic [3:0]        alu_a,
   output logic [3:0]        alu_b,
   output logic [2:0]        alu_sel,
   input  logic [3:0]        alu_result,
   input  logic              alu_carryout,
   input  logic              alu_zero,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [3:0]        rsp_result,
   output logic              rsp_carry,
   output logic              rsp_zero,
   output logic              busy,
   output logic [7:0]        op_count
);

   import alu_rr_scheduler_pkg::*;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            w_advance;
   logic [NREQ-1:0] w_gnt_onehot;
   logic [IDW-1:0]  w_gnt_idx;
   logic [3:0]      w_a;
   logic [3:0]      w_b;
   logic [2:0]      w_sel;
   logic [3:0]      r_alu_a;
   logic [3:0]      r_alu_b;
   logic [2:0]      r_alu_sel;
   logic [IDW-1:0]  r_rsp_id;
   logic            r_rsp_valid;
   logic [3:0]      r_rsp_result;
   logic            r_rsp_carry;
   logic            r_rsp_zero;
   logic [7:0]      r_op_count;

   alu_rr_scheduler_rr_arbiter #(
      .NREQ(NREQ),
      .IDW (IDW)
   ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req_valid),
      .advance   (w_advance),
      .gnt_onehot(w_gnt_onehot),
      .gnt_idx   (w_gnt_idx)
   );

   // Mux the granted requester's operands onto the ALU input path.
   always_comb begin
      w_a   = '0;
      w_b   = '0;
      w_sel = ALU_ADD;
      for (int i = 0; i < NREQ; i++) begin
         if (w_gnt_onehot[i]) begin
            w_a   = req_a[4*i +: 4];
            w_b   = req_b[4*i +: 4];
            w_sel = req_sel[3*i +: 3];
         end
      end
   end

   // Next state and request handshake; requests are only accepted while idle.
   always_comb begin
      w_state_nxt = r_state;
      w_advance   = 1'b0;
      req_ready   = '0;
      case (r_state)
         S_IDLE: begin
            if (|req_valid) begin
               w_advance   = 1'b1;
               req_ready   = w_gnt_onehot;
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: w_state_nxt = S_RESP;
         S_RESP: if (rsp_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Operand capture on accept, result capture after the settle cycle, completion count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_sel    <= ALU_ADD;
         r_rsp_id     <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_result <= '0;
         r_rsp_carry  <= 1'b0;
         r_rsp_zero   <= 1'b0;
         r_op_count   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_advance) begin
                  r_alu_a   <= w_a;
                  r_alu_b   <= w_b;
                  r_alu_sel <= w_sel;
                  r_rsp_id  <= w_gnt_idx;
               end
            end
            S_EXEC: begin
               r_rsp_result <= alu_result;
               r_rsp_carry  <= alu_carryout;
               r_rsp_zero   <= alu_zero;
               r_rsp_valid  <= 1'b1;
            end
            S_RESP: begin
               if (r_rsp_valid && rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_op_count  <= r_op_count + 8'd1;
               end
            end
            default: r_rsp_valid <= 1'b0;
         endcase
      end
   end

   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign alu_sel    = r_alu_sel;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_id     = r_rsp_id;
   assign rsp_result = r_rsp_result;
   assign rsp_carry  = r_rsp_carry;
   assign rsp_zero   = r_rsp_zero;
   assign busy       = (r_state != S_IDLE);
   assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler with a behavioural ALU closing the loop.
module tb_alu_rr_scheduler;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [11:0] req_sel;
   logic [3:0]  alu_a;
   logic [3:0]  alu_b;
   logic [2:0]  alu_sel;
   logic [3:0]  alu_result;
   logic        alu_carryout;
   logic        alu_zero;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [3:0]  rsp_result;
   logic        rsp_carry;
   logic        rsp_zero;
   logic        busy;
   logic [7:0]  op_count;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_cnt  = 0;

   alu_rr_scheduler #(
      .NREQ(4),
      .IDW (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_sel     (req_sel),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_sel     (alu_sel),
      .alu_result  (alu_result),
      .alu_carryout(alu_carryout),
      .alu_zero    (alu_zero),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_result  (rsp_result),
      .rsp_carry   (rsp_carry),
      .rsp_zero    (rsp_zero),
      .busy        (busy),
      .op_count    (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: carry is the 5th bit of the add/subtract (borrow on SUB/DEC).
   logic [4:0] m_w;
   always_comb begin
      m_w = '0;
      case (alu_sel)
         3'd0: m_w = {1'b0, alu_a} + {1'b0, alu_b};
         3'd1: m_w = {1'b0, alu_a} - {1'b0, alu_b};
         3'd2: m_w = {1'b0, alu_a & alu_b};
         3'd3: m_w = {1'b0, alu_a | alu_b};
         3'd4: m_w = {1'b0, alu_a ^ alu_b};
         3'd5: m_w = {1'b0, ~alu_a};
         3'd6: m_w = {1'b0, alu_a} + 5'd1;
         default: m_w = {1'b0, alu_a} - 5'd1;
      endcase
   end
   assign alu_result   = m_w[3:0];
   assign alu_carryout = m_w[4];
   assign alu_zero     = (m_w[3:0] == 4'd0);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_ops(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
      req_a   = {4{a}};
      req_b   = {4{b}};
      req_sel = {4{sel}};
   endtask

   // Full transaction with rsp_ready=1; entered just after a negedge with the DUT idle.
   task automatic issue_op(input string tag, input logic [3:0] vld, input logic [3:0] exp_gnt,
                           input logic [1:0] exp_id, input logic [3:0] exp_res,
                           input logic exp_c, input logic exp_z, input logic [2:0] exp_sel);
      chk({tag, ".idle"}, 32'(busy), 0);
      req_valid = vld;
      #1;
      chk({tag, ".ready"}, 32'(req_ready), 32'(exp_gnt));
      @(negedge clk);
      req_valid = '0;
      #1;
      chk({tag, ".exec_ready"}, 32'(req_ready), 0);
      @(negedge clk);
      #1;
      chk({tag, ".rsp_valid"}, 32'(rsp_valid), 1);
      chk({tag, ".rsp_id"}, 32'(rsp_id), 32'(exp_id));
      chk({tag, ".result"}, 32'(rsp_result), 32'(exp_res));
      chk({tag, ".carry"}, 32'(rsp_carry), 32'(exp_c));
      chk({tag, ".zero"}, 32'(rsp_zero), 32'(exp_z));
      chk({tag, ".alu_sel"}, 32'(alu_sel), 32'(exp_sel));
      @(negedge clk);
      exp_cnt++;
      #1;
      chk({tag, ".done"}, 32'(rsp_valid), 0);
      chk({tag, ".op_count"}, 32'(op_count), 32'(exp_cnt));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      set_ops(4'h7, 4'h9, 3'b000);
      repeat (2) @(negedge clk);
      #1;
      chk("rst.rsp_valid", 32'(rsp_valid), 0);
      chk("rst.alu_sel", 32'(alu_sel), 0);
      chk("rst.op_count", 32'(op_count), 0);
      chk("rst.busy", 32'(busy), 0);
      chk("rst.req_ready", 32'(req_ready), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single op from requester 0: 7+9 overflows to 0 with carry.
      issue_op("t1_add", 4'b0001, 4'b0001, 2'd0, 4'h0, 1'b1, 1'b1, 3'b000);

      // Fresh pointer, all requesters valid: grants 0,1,2,3,0 every 3 cycles.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n   = 1'b1;
      exp_cnt = 0;
      req_a   = 16'h4321;
      req_b   = 16'h2222;
      req_sel = '0;
      req_valid = 4'hF;
      for (int c = 0; c < 15; c++) begin
         #1;
         if (c % 3 == 0) begin
            chk("t2.grant", 32'(req_ready), 32'(1 << ((c / 3) % 4)));
            chk("t2.op_count", 32'(op_count), 32'(c / 3));
         end else if (c % 3 == 1) begin
            chk("t2.exec_ready", 32'(req_ready), 0);
         end else begin
            chk("t2.rsp_valid", 32'(rsp_valid), 1);
            chk("t2.rsp_id", 32'(rsp_id), 32'((c / 3) % 4));
            chk("t2.result", 32'(rsp_result), 32'((c / 3) % 4 + 3));
         end
         @(negedge clk);
      end
      req_valid = '0;
      exp_cnt   = 5;
      #1;
      chk("t2.final_count", 32'(op_count), 32'(exp_cnt));

      // Backpressure: SUB 2-5 from requester 2 held for 10 cycles.
      rsp_ready = 1'b0;
      set_ops(4'h2, 4'h5, 3'b001);
      req_valid = 4'b0100;
      #1;
      chk("t3.grant", 32'(req_ready), 32'(4'b0100));
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      req_valid = 4'hF;
      for (int k = 0; k < 10; k++) begin
         #1;
         chk("t3.rsp_valid", 32'(rsp_valid), 1);
         chk("t3.result", 32'(rsp_result), 32'hD);
         chk("t3.carry", 32'(rsp_carry), 1);
         chk("t3.zero", 32'(rsp_zero), 0);
         chk("t3.rsp_id", 32'(rsp_id), 2);
         chk("t3.alu_a", 32'(alu_a), 2);
         chk("t3.req_ready", 32'(req_ready), 0);
         @(negedge clk);
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      @(negedge clk);
      exp_cnt++;
      #1;
      chk("t3.released", 32'(rsp_valid), 0);
      chk("t3.busy", 32'(busy), 0);
      chk("t3.op_count", 32'(op_count), 32'(exp_cnt));

      // Wrap and fairness: pointer at 3 after granting 2.
      set_ops(4'h1, 4'h1, 3'b000);
      issue_op("t4_w3", 4'b1001, 4'b1000, 2'd3, 4'h2, 1'b0, 1'b0, 3'b000);
      issue_op("t4_w0", 4'b1001, 4'b0001, 2'd0, 4'h2, 1'b0, 1'b0, 3'b000);
      issue_op("t4_to3", 4'b1000, 4'b1000, 2'd3, 4'h2, 1'b0, 1'b0, 3'b000);
      issue_op("t4_p0_3", 4'b1000, 4'b1000, 2'd3, 4'h2, 1'b0, 1'b0, 3'b000);
      issue_op("t4_p0", 4'b1111, 4'b0001, 2'd0, 4'h2, 1'b0, 1'b0, 3'b000);

      // Individual ops through requester 1.
      set_ops(4'h2, 4'h5, 3'b001);
      issue_op("t5_sub", 4'b0010, 4'b0010, 2'd1, 4'hD, 1'b1, 1'b0, 3'b001);
      set_ops(4'h0, 4'h0, 3'b111);
      issue_op("t5_dec", 4'b0010, 4'b0010, 2'd1, 4'hF, 1'b1, 1'b0, 3'b111);
      set_ops(4'hF, 4'h0, 3'b101);
      issue_op("t5_not", 4'b0010, 4'b0010, 2'd1, 4'h0, 1'b0, 1'b1, 3'b101);
      set_ops(4'hF, 4'h0, 3'b110);
      issue_op("t5_inc", 4'b0010, 4'b0010, 2'd1, 4'h0, 1'b1, 1'b1, 3'b110);
      set_ops(4'hA, 4'h5, 3'b100);
      issue_op("t5_xor", 4'b0010, 4'b0010, 2'd1, 4'hF, 1'b0, 1'b0, 3'b100);
      set_ops(4'hC, 4'hA, 3'b010);
      issue_op("t5_and", 4'b0010, 4'b0010, 2'd1, 4'h8, 1'b0, 1'b0, 3'b010);
      set_ops(4'h0, 4'h0, 3'b011);
      issue_op("t5_or", 4'b0010, 4'b0010, 2'd1, 4'h0, 1'b0, 1'b1, 3'b011);

      // Asynchronous reset while a response is stalled.
      rsp_ready = 1'b0;
      set_ops(4'h3, 4'h4, 3'b000);
      req_valid = 4'b0100;
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      #1;
      chk("t6.rsp_valid_pre", 32'(rsp_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6.rsp_valid", 32'(rsp_valid), 0);
      chk("t6.result", 32'(rsp_result), 0);
      chk("t6.alu_a", 32'(alu_a), 0);
      chk("t6.busy", 32'(busy), 0);
      chk("t6.op_count", 32'(op_count), 0);
      @(negedge clk);
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      req_valid = 4'hF;
      #1;
      chk("t6.first_grant", 32'(req_ready), 32'(4'b0001));
      req_valid = '0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
